// File: rtl/ssl_frame_sched_if.sv
// Downstream word channel of the frame scheduler: one lag index per beat,
// tagged with its channel and frame sequence number, over valid/ready.
interface ssl_frame_sched_if #(
  parameter int NDATA_LOG = 7,
  parameter int SEQW      = 8
);
  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           out_ch;
  logic [NDATA_LOG-1:0] out_id;
  logic [SEQW-1:0]      out_seq;

  modport master (output out_valid, out_ch, out_id, out_seq, input out_ready);
  modport slave  (input out_valid, out_ch, out_id, out_seq, output out_ready);
endinterface

// File: rtl/ssl_frame_sched.sv
// Captures the A/B/C lag indices at each frame boundary and serialises them
// to a single consumer; frames arriving while a frame is still in flight are dropped.
//
// state | meaning
// IDLE  | not running, waiting for start
// ARM   | running, discarding the partial frame up to the first boundary
// WAIT  | running, waiting for the next boundary to capture a frame
// SEND  | presenting captured words A, B, C in order
module ssl_frame_sched #(
  parameter int NDATA     = 128,
  parameter int NDATA_LOG = $clog2(NDATA),
  parameter int SEQW      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [NDATA_LOG-1:0] cntin,
  input  logic [NDATA_LOG-1:0] idA,
  input  logic [NDATA_LOG-1:0] idB,
  input  logic [NDATA_LOG-1:0] idC,
  input  logic                 start,
  input  logic [7:0]           frames,
  ssl_frame_sched_if.master    word,
  output logic                 busy,
  output logic                 overrun,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, ARM, WAIT, SEND} state_t;

  state_t               state;
  logic [NDATA_LOG-1:0] hold_a, hold_b, hold_c;
  logic [SEQW-1:0]      seq_ctr, cap_seq;
  logic [7:0]           rem;
  logic                 cont;
  logic [1:0]           idx;
  logic                 boundary, xfer;

  assign boundary = ena && (cntin == NDATA_LOG'(NDATA - 1));
  assign xfer     = ena && word.out_valid && word.out_ready;

  assign busy           = (state != IDLE);
  assign word.out_valid = (state == SEND);
  assign word.out_ch    = idx;
  assign word.out_seq   = cap_seq;

  always_comb begin
    case (idx)
      2'd0:    word.out_id = hold_a;
      2'd1:    word.out_id = hold_b;
      default: word.out_id = hold_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      hold_a  <= '0;
      hold_b  <= '0;
      hold_c  <= '0;
      seq_ctr <= '0;
      cap_seq <= '0;
      rem     <= '0;
      cont    <= 1'b0;
      idx     <= 2'd0;
      overrun <= 1'b0;
      done    <= 1'b0;
    end else if (ena) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ARM;
            rem     <= frames;
            cont    <= (frames == 8'd0);
            seq_ctr <= '0;
            overrun <= 1'b0;
          end
        end
        ARM: begin
          if (!start)        state <= IDLE;
          else if (boundary) state <= WAIT;
        end
        WAIT: begin
          if (boundary) begin
            hold_a  <= idA;
            hold_b  <= idB;
            hold_c  <= idC;
            cap_seq <= seq_ctr;
            seq_ctr <= seq_ctr + 1'b1;
            idx     <= 2'd0;
            state   <= SEND;
          end else if (!start) begin
            state <= IDLE;
          end
        end
        SEND: begin
          if (xfer && idx == 2'd2) begin
            idx <= 2'd0;
            // A counted run ends on its last frame even if a boundary coincides.
            if (!cont && rem == 8'd1) begin
              state <= IDLE;
              done  <= 1'b1;
            end else if (!start) begin
              state <= IDLE;
            end else begin
              if (!cont) rem <= rem - 8'd1;
              if (boundary) begin
                hold_a  <= idA;
                hold_b  <= idB;
                hold_c  <= idC;
                cap_seq <= seq_ctr;
                seq_ctr <= seq_ctr + 1'b1;
              end else begin
                state <= WAIT;
              end
            end
          end else begin
            if (xfer) idx <= idx + 2'd1;
            // Frame lost while busy: it still consumes a sequence number.
            if (boundary) begin
              overrun <= 1'b1;
              seq_ctr <= seq_ctr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
